// File: rtl/fifo_flags.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost flags,
// overflow/underflow pulses, synchronous flush and optional first-word fall-through.
module fifo_flags #(
    parameter int FIFO_WIDTH    = 4,
    parameter int N_ADDR_BITS   = 2,
    parameter int AFULL_THRESH  = (2 ** N_ADDR_BITS) - 1,
    parameter int AEMPTY_THRESH = 1,
    parameter bit FWFT          = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [FIFO_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [N_ADDR_BITS:0]  count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** N_ADDR_BITS;
    localparam int CW    = N_ADDR_BITS + 1;

    localparam logic [CW-1:0]          DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0]          AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0]          AEMPTY_C = CW'(AEMPTY_THRESH);
    localparam logic [CW-1:0]          CNT_ONE  = CW'(1);
    localparam logic [N_ADDR_BITS-1:0] PTR_ONE  = N_ADDR_BITS'(1);

    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH >= AFULL_THRESH || AFULL_THRESH > DEPTH) begin : g_bad_thresh
        $error("fifo_flags: thresholds must satisfy 0 <= AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
    end

    logic [FIFO_WIDTH-1:0]  mem_reg [DEPTH];
    logic [N_ADDR_BITS-1:0] wr_ptr_reg, wr_ptr_next;
    logic [N_ADDR_BITS-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]          count_reg, count_next;
    logic                   overflow_reg, overflow_next;
    logic                   underflow_reg, underflow_next;
    logic                   rd_ok, wr_ok;

    // Flags depend only on the registered count, never on this cycle's requests.
    assign empty        = (count_reg == '0);
    assign full         = (count_reg == DEPTH_C);
    assign almost_empty = (count_reg <= AEMPTY_C);
    assign almost_full  = (count_reg >= AFULL_C);
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_ok = rd_en & ~empty;
    assign wr_ok = wr_en & (~full | rd_ok);

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        overflow_next  = 1'b0;
        underflow_next = 1'b0;
        if (clear) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end
            if (wr_ok && !rd_ok) begin
                count_next = count_reg + CNT_ONE;
            end else if (rd_ok && !wr_ok) begin
                count_next = count_reg - CNT_ONE;
            end
            overflow_next  = wr_en & ~wr_ok;
            underflow_next = rd_en & ~rd_ok;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // Storage is never reset or flushed; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok && !clear) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

    if (FWFT) begin : g_fwft
        assign rd_data  = mem_reg[rd_ptr_reg];
        assign rd_valid = ~empty;
    end else begin : g_registered
        logic [FIFO_WIDTH-1:0] rd_data_reg;
        logic                  rd_valid_reg;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rd_data_reg  <= '0;
                rd_valid_reg <= 1'b0;
            end else if (clear) begin
                rd_valid_reg <= 1'b0;
            end else begin
                rd_valid_reg <= rd_ok;
                if (rd_ok) begin
                    rd_data_reg <= mem_reg[rd_ptr_reg];
                end
            end
        end

        assign rd_data  = rd_data_reg;
        assign rd_valid = rd_valid_reg;
    end

endmodule

// File: doc/fifo_flags.md
# fifo_flags

Parametrised synchronous FIFO, the next generation of the lab FIFO. It adds configurable width and depth, an occupancy count, programmable almost-full and almost-empty flags, overflow and underflow error pulses, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode. It sits between a producer and a consumer in the same clock domain and is a drop-in superset of the basic FIFO port set.

## Interface
- FIFO_WIDTH, default 4: data width in bits.
- N_ADDR_BITS, default 2: address bits; DEPTH = 2**N_ADDR_BITS entries.
- AFULL_THRESH, default DEPTH-1: almost_full asserts when count >= AFULL_THRESH.
- AEMPTY_THRESH, default 1: almost_empty asserts when count <= AEMPTY_THRESH.
- FWFT, default 0: 0 selects registered read; 1 selects first-word fall-through.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- clear  in  1  synchronous flush; empties the FIFO.
- wr_en  in  1  write request.
- wr_data  in  FIFO_WIDTH  write data.
- rd_en  in  1  read request (FWFT=1: acknowledges the current head).
- rd_data  out  FIFO_WIDTH  read data.
- rd_valid  out  1  rd_data holds a valid word.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- almost_full  out  1  count >= AFULL_THRESH.
- count  out  N_ADDR_BITS+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.

## Operation
- Storage: DEPTH x FIFO_WIDTH register array, with rd_ptr and wr_ptr of N_ADDR_BITS bits each. Pointers wrap naturally from DEPTH-1 to 0. count is a separate register.
- Acceptance, evaluated each edge from registered state:
  - rd_ok = rd_en & !empty.
  - wr_ok = wr_en & (!full | rd_ok).
  - A write to a full FIFO is accepted only when a read is accepted in the same cycle.
  - A read of an empty FIFO is always rejected, even with a simultaneous write.
- wr_ok: mem[wr_ptr] <= wr_data; wr_ptr++.
- rd_ok: rd_ptr++.
- count: +1 on wr_ok only; -1 on rd_ok only; unchanged when both or neither.
- Errors: overflow <= wr_en & !wr_ok; underflow <= rd_en & !rd_ok. Both are registered pulses that assert in the cycle after the request.
- FWFT=0: on rd_ok, rd_data <= mem[rd_ptr] and rd_valid <= 1. Otherwise rd_valid <= 0 and rd_data holds its last value.
- FWFT=1: rd_data = mem[rd_ptr] combinationally; rd_valid = !empty. rd_en pops the displayed word.
- Flags are decoded combinationally from the count register only, with no dependence on the current wr_en/rd_en.
- clear: pointers, count, rd_valid, overflow and underflow go to 0; memory contents are not cleared. Requests in a clear cycle are ignored and raise no error pulse.
- Priority: reset > clear > read/write.

## Timing
- Reset values, asynchronous:
  - count=0, empty=1, full=0, almost_empty=1, almost_full=0.
  - rd_valid=0, rd_data=0 (FWFT=0), overflow=0, underflow=0.
  - Pointers = 0.
- Reset asserted mid-operation drops all data immediately. The first write after reset lands at address 0.
- Write-to-empty-deassert latency is 1 cycle: empty falls the cycle after the accepted write.
- Read latency:
  - FWFT=0: data appears 1 cycle after rd_en is sampled with rd_ok.
  - FWFT=1: data appears 1 cycle after the first write into an empty FIFO, with 0 read latency thereafter.
- full rises the cycle after the DEPTH-th unmatched write; it falls the cycle after an accepted read.
- Simultaneous read+write at count == DEPTH or at 0 < count < DEPTH: both accepted, count unchanged, flags unchanged.
- Simultaneous read+write at count == 0: write accepted, read rejected, underflow pulses, count becomes 1.
- Thresholds must satisfy 0 <= AEMPTY_THRESH < AFULL_THRESH <= DEPTH; the elaboration check fails otherwise.

## Test plan
All scenarios use defaults (FIFO_WIDTH=4, N_ADDR_BITS=2, DEPTH=4) unless noted.
- Reset then fill: write 4'h3, 4'hA, 4'h5, 4'hC on consecutive cycles. Required: count steps 1,2,3,4; almost_full at count 3; full at count 4; empty cleared after the first write.
- Overflow: with the FIFO full, write 4'hF alone. Required: overflow pulses 1 cycle, count stays 4, and the subsequent drain returns 3,A,5,C in order (FWFT=0, each 1 cycle after rd_en).
- Underflow: rd_en on an empty FIFO. Required: underflow pulses, rd_valid stays 0, count stays 0. Then read+write 4'h7 together at count 0. Required: underflow pulses again, count becomes 1.
- Full simultaneous: at count 4, assert rd_en and wr_en with 4'h9. Required: both accepted, count stays 4, no error pulses, and the 4th subsequent read returns 9.
- Wrap-around: alternate single write/read for 10 cycles with random data. Required: every read matches its write, pointers wrap past 3, and count toggles 0/1.
- FWFT=1 and reset/clear: write 4'h6. Required: rd_data=6 and rd_valid=1 on the next cycle, before any rd_en. Then assert clear at count 2, and separately reset mid-fill. Required in both cases: count=0, empty=1, rd_valid=0 immediately (reset) or on the next edge (clear).
